lc3_control: RTL and testbench
==============================

Name: lc3_control

Overview:
- Multi-cycle LC-3 control FSM that drives every control input of the LC-3 datapath.
- Consumes the datapath's IR, the N/Z/P flags and a memory-ready handshake from the memory responder.
- Sequences fetch, decode and execute for the LC-3 ISA, minus RTI.
- Sits between the datapath and the memory block; owns memory enable and write strobes.

Parameters:
- MEM_TIMEOUT, 255: max cycles to wait for mem_rdy (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- IR  in  16  instruction register from datapath
- N, Z, P  in  1 each  condition flags from datapath
- mem_rdy  in  1  memory completes current access this cycle
- mem_en  out  1  memory access request
- mem_we  out  1  write request (valid with mem_en)
- aluControl  out  2  00 pass RA, 01 ADD, 10 AND, 11 NOT
- enaALU, enaPC, enaMDR, enaMARM  out  1 each  bus drivers; at most one high
- SR1, SR2, DR  out  3 each  register file selects
- logicWE, flagWE  out  1 each  register file / NZP write
- selPC  out  2  00 PC+1, 01 ADDER, 10 BUS
- selMAR  out  1  1 ZEXT(IR[7:0]), 0 ADDER
- selEAB1  out  1  0 PC, 1 RA
- selEAB2  out  2  00 zero, 01 off6, 10 off9, 11 off11
- ldPC, ldIR, ldMAR, ldMDR  out  1 each  register loads
- selMDR  out  1  1 memory, 0 bus
- halted  out  1  FSM in HALT
- illegal  out  1  HALT caused by illegal opcode

Behaviour:
- Reset (rst_n low, async): state=RST; every output 0. First clk after release: RST->F1.
- Outputs are Moore decode of state+IR. The only exception: ldMDR in read states = mem_rdy.
- Unlisted outputs are 0 in every state.
- Fetch:
  - F1: enaPC, ldMAR, ldPC, selPC=00.
  - F2: mem_en, selMDR=1, ldMDR=mem_rdy; hold until mem_rdy.
  - F3: enaMDR, ldIR.
  - F3->DEC.
- DEC dispatches on IR[15:12]:
  - 0001/0101/1001 (ADD/AND/NOT): enaALU, logicWE, flagWE, DR=IR[11:9], SR1=IR[8:6], SR2=IR[2:0]. aluControl=01/10/11. ->F1.
  - 0000 BR: if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), ldPC, selPC=01, selEAB1=0, selEAB2=10. ->F1. All condition bits 0 = no-op.
  - 1100 JMP: ldPC, selPC=01, selEAB1=1, selEAB2=00, SR1=IR[8:6].
  - 0100 JSR/JSRR: one state. enaPC, logicWE, DR=7, ldPC, selPC=01.
    - IR[11]=1: selEAB1=0, selEAB2=11.
    - IR[11]=0: selEAB1=1, SR1=IR[8:6], selEAB2=00.
    - JSRR R7 jumps to old R7: RA is read before the edge.
  - 1110 LEA: enaMARM, selMAR=0, off9, logicWE, flagWE.
  - 0010/0110 LD/LDR:
    - ADDR state: enaMARM, ldMAR (PC+off9 or BaseR+off6).
    - RD state: mem wait, as F2.
    - WB state: enaMDR, logicWE, flagWE.
  - 1010 LDI: ADDR -> RD -> IND (enaMDR, ldMAR) -> RD -> WB.
  - 0011/0111 ST/STR:
    - ADDR state.
    - SMDR state: enaALU, aluControl=00, SR1=IR[11:9], ldMDR, selMDR=0.
    - WR state: mem_en, mem_we; hold until mem_rdy.
    - ->F1.
  - 1011 STI: ADDR -> RD -> IND -> SMDR -> WR.
  - 1111 TRAP:
    - T1: enaMARM, selMAR=1, ldMAR.
    - T2: enaPC, logicWE, DR=7.
    - IR[7:0]=x25: -> HALT.
    - Else T3 (mem read) -> T4: enaMDR, ldPC, selPC=10.
  - 1000/1101: -> HALT, illegal=1.
- mem_en/mem_we stay stable from assertion until the mem_rdy cycle inclusive.
- mem_rdy outside a memory state is ignored.
- HALT is absorbing; only reset exits. halted=1, all strobes 0.
- Reset mid-access drops mem_en immediately.

Optional Feature:
- LC3_CTRL_MEM_TIMEOUT_EN defined:
  - An 8-bit+ counter runs in each memory wait state and clears on state entry.
  - If MEM_TIMEOUT cycles pass without mem_rdy: -> HALT, illegal=0, extra output timeout=1.
- Undefined: waits indefinitely; no counter, no timeout port.

Decomposition:
- lc3_pkg:
  - opcode enum
  - FSM state enum
  - selPC/selEAB2/aluControl encodings
  - TRAP_HALT=8'h25
- Sub-module lc3_ctrl_outdec: purely combinational state+IR+flags -> control vector.
- lc3_control keeps the state register, transitions and the timeout counter.

Test Plan:
- Reset release, memory zero-wait. Expect:
  - F1 on cycle 1: enaPC=1, ldMAR=1.
  - mem_en in cycle 2.
  - ldIR in cycle 3.
- IR=16'h1261 (ADD R1,R1,#1): expect DEC with enaALU=1, aluControl=01, DR=1, SR1=1, logicWE=1, flagWE=1, then F1.
- IR=16'h0402 (BRz), Z=1 then Z=0: expect ldPC=1, selPC=01, selEAB2=10 only when Z=1.
- IR=16'h3003 (ST R0), mem_rdy delayed 3 cycles: expect mem_en=1, mem_we=1 held 4 cycles, then F1.
- IR=16'h4040 (JSRR R1): expect a single cycle with enaPC=1, DR=7, logicWE=1, ldPC=1, selEAB1=1, SR1=1.
- IR=16'hF025 then IR=16'h8000: expect halted=1 (and illegal=1 for 8000). Under LC3_CTRL_MEM_TIMEOUT_EN with mem_rdy=0: expect timeout=1 after 255 cycles.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 control types: opcodes, FSM states, mux encodings and the control vector.
package lc3_pkg;

   typedef enum logic [3:0] {
      OP_BR   = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST   = 4'b0011,
      OP_JSR  = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR  = 4'b0111,
      OP_RTI  = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI  = 4'b1011,
      OP_JMP  = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
   } opcode_e;

   typedef enum logic [3:0] {
      S_RST, S_F1, S_F2, S_F3, S_DEC, S_ADDR, S_RD, S_IND,
      S_WB, S_SMDR, S_WR, S_T1, S_T2, S_T3, S_T4, S_HALT
   } state_e;

   localparam logic [1:0] SELPC_INC   = 2'b00;
   localparam logic [1:0] SELPC_ADDER = 2'b01;
   localparam logic [1:0] SELPC_BUS   = 2'b10;

   localparam logic [1:0] EAB2_ZERO  = 2'b00;
   localparam logic [1:0] EAB2_OFF6  = 2'b01;
   localparam logic [1:0] EAB2_OFF9  = 2'b10;
   localparam logic [1:0] EAB2_OFF11 = 2'b11;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOT  = 2'b11;

   localparam logic [7:0] TRAP_HALT = 8'h25;

   typedef struct packed {
      logic       mem_en;
      logic       mem_we;
      logic [1:0] alu;
      logic       ena_alu;
      logic       ena_pc;
      logic       ena_mdr;
      logic       ena_marm;
      logic [2:0] sr1;
      logic [2:0] sr2;
      logic [2:0] dr;
      logic       logic_we;
      logic       flag_we;
      logic [1:0] sel_pc;
      logic       sel_mar;
      logic       sel_eab1;
      logic [1:0] sel_eab2;
      logic       ld_pc;
      logic       ld_ir;
      logic       ld_mar;
      logic       ld_mdr;
      logic       sel_mdr;
      logic       halted;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_mem_wait(input state_e s);
      return (s == S_F2) || (s == S_RD) || (s == S_T3) || (s == S_WR);
   endfunction

endpackage

// File: rtl/lc3_ctrl_outdec.sv
// Combinational control-vector decode from FSM state, IR, NZP flags and mem_rdy.
module lc3_ctrl_outdec
   import lc3_pkg::*;
(
   input  state_e      state,
   input  logic [15:0] ir,
   input  logic        n,
   input  logic        z,
   input  logic        p,
   input  logic        mem_rdy,
   output ctrl_t       ctrl
);

   opcode_e op;
   logic    unused_ir;

   assign op        = opcode_e'(ir[15:12]);
   assign unused_ir = ^ir[5:3];

   always_comb begin
      ctrl = '0;
      case (state)
         S_F1: begin
            ctrl.ena_pc = 1'b1;
            ctrl.ld_mar = 1'b1;
            ctrl.ld_pc  = 1'b1;
            ctrl.sel_pc = SELPC_INC;
         end
         S_F2, S_RD, S_T3: begin
            ctrl.mem_en  = 1'b1;
            ctrl.sel_mdr = 1'b1;
            ctrl.ld_mdr  = mem_rdy;
         end
         S_F3: begin
            ctrl.ena_mdr = 1'b1;
            ctrl.ld_ir   = 1'b1;
         end
         S_DEC: begin
            case (op)
               OP_ADD, OP_AND, OP_NOT: begin
                  ctrl.ena_alu  = 1'b1;
                  ctrl.logic_we = 1'b1;
                  ctrl.flag_we  = 1'b1;
                  ctrl.dr       = ir[11:9];
                  ctrl.sr1      = ir[8:6];
                  ctrl.sr2      = ir[2:0];
                  ctrl.alu      = (op == OP_ADD) ? ALU_ADD : (op == OP_AND) ? ALU_AND : ALU_NOT;
               end
               OP_BR: begin
                  if ((ir[11] & n) | (ir[10] & z) | (ir[9] & p)) begin
                     ctrl.ld_pc    = 1'b1;
                     ctrl.sel_pc   = SELPC_ADDER;
                     ctrl.sel_eab2 = EAB2_OFF9;
                  end
               end
               OP_JMP: begin
                  ctrl.ld_pc    = 1'b1;
                  ctrl.sel_pc   = SELPC_ADDER;
                  ctrl.sel_eab1 = 1'b1;
                  ctrl.sel_eab2 = EAB2_ZERO;
                  ctrl.sr1      = ir[8:6];
               end
               OP_JSR: begin
                  // R7 gets PC while PC takes the target; RA is sampled before the edge
                  ctrl.ena_pc   = 1'b1;
                  ctrl.logic_we = 1'b1;
                  ctrl.dr       = 3'd7;
                  ctrl.ld_pc    = 1'b1;
                  ctrl.sel_pc   = SELPC_ADDER;
                  if (ir[11]) begin
                     ctrl.sel_eab2 = EAB2_OFF11;
                  end else begin
                     ctrl.sel_eab1 = 1'b1;
                     ctrl.sr1      = ir[8:6];
                     ctrl.sel_eab2 = EAB2_ZERO;
                  end
               end
               OP_LEA: begin
                  ctrl.ena_marm = 1'b1;
                  ctrl.sel_eab2 = EAB2_OFF9;
                  ctrl.logic_we = 1'b1;
                  ctrl.flag_we  = 1'b1;
                  ctrl.dr       = ir[11:9];
               end
               default: ;
            endcase
         end
         S_ADDR: begin
            ctrl.ena_marm = 1'b1;
            ctrl.ld_mar   = 1'b1;
            if (op == OP_LDR || op == OP_STR) begin
               ctrl.sel_eab1 = 1'b1;
               ctrl.sr1      = ir[8:6];
               ctrl.sel_eab2 = EAB2_OFF6;
            end else begin
               ctrl.sel_eab2 = EAB2_OFF9;
            end
         end
         S_IND: begin
            ctrl.ena_mdr = 1'b1;
            ctrl.ld_mar  = 1'b1;
         end
         S_WB: begin
            ctrl.ena_mdr  = 1'b1;
            ctrl.logic_we = 1'b1;
            ctrl.flag_we  = 1'b1;
            ctrl.dr       = ir[11:9];
         end
         S_SMDR: begin
            ctrl.ena_alu = 1'b1;
            ctrl.alu     = ALU_PASS;
            ctrl.sr1     = ir[11:9];
            ctrl.ld_mdr  = 1'b1;
         end
         S_WR: begin
            ctrl.mem_en = 1'b1;
            ctrl.mem_we = 1'b1;
         end
         S_T1: begin
            ctrl.ena_marm = 1'b1;
            ctrl.sel_mar  = 1'b1;
            ctrl.ld_mar   = 1'b1;
         end
         S_T2: begin
            ctrl.ena_pc   = 1'b1;
            ctrl.logic_we = 1'b1;
            ctrl.dr       = 3'd7;
         end
         S_T4: begin
            ctrl.ena_mdr = 1'b1;
            ctrl.ld_pc   = 1'b1;
            ctrl.sel_pc  = SELPC_BUS;
         end
         S_HALT: begin
            ctrl.halted  = 1'b1;
            ctrl.illegal = (op == OP_RTI) || (op == OP_RES);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lc3_control.sv
// Multi-cycle LC-3 control FSM: state register, transitions, output decode instance.
// Optional memory-wait timeout enabled by defining LC3_CTRL_MEM_TIMEOUT_EN.
module lc3_control
   import lc3_pkg::*;
`ifdef LC3_CTRL_MEM_TIMEOUT_EN
   #(parameter int MEM_TIMEOUT = 255)
`endif
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] IR,
   input  logic        N,
   input  logic        Z,
   input  logic        P,
   input  logic        mem_rdy,
   output logic        mem_en,
   output logic        mem_we,
   output logic [1:0]  aluControl,
   output logic        enaALU,
   output logic        enaPC,
   output logic        enaMDR,
   output logic        enaMARM,
   output logic [2:0]  SR1,
   output logic [2:0]  SR2,
   output logic [2:0]  DR,
   output logic        logicWE,
   output logic        flagWE,
   output logic [1:0]  selPC,
   output logic        selMAR,
   output logic        selEAB1,
   output logic [1:0]  selEAB2,
   output logic        ldPC,
   output logic        ldIR,
   output logic        ldMAR,
   output logic        ldMDR,
   output logic        selMDR,
   output logic        halted,
   output logic        illegal
`ifdef LC3_CTRL_MEM_TIMEOUT_EN
   ,
   output logic        timeout
`endif
);

   state_e  state, state_n;
   logic    ind_q, ind_n;
   opcode_e op;
   ctrl_t   ctrl;

   assign op = opcode_e'(IR[15:12]);

`ifdef LC3_CTRL_MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] cnt;
   logic             tmo_hit, timeout_q;

   assign tmo_hit = is_mem_wait(state) && !mem_rdy && (cnt == CNT_W'(MEM_TIMEOUT - 1));
`endif

   always_comb begin
      state_n = state;
      ind_n   = ind_q;
      case (state)
         S_RST:  state_n = S_F1;
         S_F1:   state_n = S_F2;
         S_F2:   if (mem_rdy) state_n = S_F3;
         S_F3:   state_n = S_DEC;
         S_DEC: begin
            ind_n = 1'b0;
            case (op)
               OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: state_n = S_ADDR;
               OP_TRAP:        state_n = S_T1;
               OP_RTI, OP_RES: state_n = S_HALT;
               default:        state_n = S_F1;
            endcase
         end
         S_ADDR: state_n = (op == OP_ST || op == OP_STR) ? S_SMDR : S_RD;
         // ind_q marks that LDI already fetched its pointer, so the next read is the data
         S_RD:   if (mem_rdy) state_n = ((op == OP_LDI && !ind_q) || op == OP_STI) ? S_IND : S_WB;
         S_IND: begin
            ind_n   = 1'b1;
            state_n = (op == OP_STI) ? S_SMDR : S_RD;
         end
         S_WB:   state_n = S_F1;
         S_SMDR: state_n = S_WR;
         S_WR:   if (mem_rdy) state_n = S_F1;
         S_T1:   state_n = S_T2;
         S_T2:   state_n = (IR[7:0] == TRAP_HALT) ? S_HALT : S_T3;
         S_T3:   if (mem_rdy) state_n = S_T4;
         S_T4:   state_n = S_F1;
         default: state_n = S_HALT;
      endcase
`ifdef LC3_CTRL_MEM_TIMEOUT_EN
      if (tmo_hit) state_n = S_HALT;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RST;
         ind_q <= 1'b0;
      end else begin
         state <= state_n;
         ind_q <= ind_n;
      end
   end

`ifdef LC3_CTRL_MEM_TIMEOUT_EN
   // Counter restarts on every state entry, so each wait gets the full budget
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (tmo_hit) timeout_q <= 1'b1;
         if (state_n != state || !is_mem_wait(state)) cnt <= '0;
         else                                         cnt <= cnt + CNT_W'(1);
      end
   end
`endif

   lc3_ctrl_outdec u_outdec (
      .state   (state),
      .ir      (IR),
      .n       (N),
      .z       (Z),
      .p       (P),
      .mem_rdy (mem_rdy),
      .ctrl    (ctrl)
   );

   assign mem_en     = ctrl.mem_en;
   assign mem_we     = ctrl.mem_we;
   assign aluControl = ctrl.alu;
   assign enaALU     = ctrl.ena_alu;
   assign enaPC      = ctrl.ena_pc;
   assign enaMDR     = ctrl.ena_mdr;
   assign enaMARM    = ctrl.ena_marm;
   assign SR1        = ctrl.sr1;
   assign SR2        = ctrl.sr2;
   assign DR         = ctrl.dr;
   assign logicWE    = ctrl.logic_we;
   assign flagWE     = ctrl.flag_we;
   assign selPC      = ctrl.sel_pc;
   assign selMAR     = ctrl.sel_mar;
   assign selEAB1    = ctrl.sel_eab1;
   assign selEAB2    = ctrl.sel_eab2;
   assign ldPC       = ctrl.ld_pc;
   assign ldIR       = ctrl.ld_ir;
   assign ldMAR      = ctrl.ld_mar;
   assign ldMDR      = ctrl.ld_mdr;
   assign selMDR     = ctrl.sel_mdr;
   assign halted     = ctrl.halted;
`ifdef LC3_CTRL_MEM_TIMEOUT_EN
   assign illegal    = ctrl.illegal & ~timeout_q;
   assign timeout    = timeout_q;
`else
   assign illegal    = ctrl.illegal;
`endif

endmodule

// File: tb/tb_lc3_control.sv
// Directed scoreboard bench for lc3_control; timeout checks under LC3_CTRL_MEM_TIMEOUT_EN.
module tb_lc3_control;

   typedef struct packed {
      logic       mem_en;
      logic       mem_we;
      logic [1:0] alu;
      logic       ena_alu;
      logic       ena_pc;
      logic       ena_mdr;
      logic       ena_marm;
      logic [2:0] sr1;
      logic [2:0] sr2;
      logic [2:0] dr;
      logic       logic_we;
      logic       flag_we;
      logic [1:0] sel_pc;
      logic       sel_mar;
      logic       sel_eab1;
      logic [1:0] sel_eab2;
      logic       ld_pc;
      logic       ld_ir;
      logic       ld_mar;
      logic       ld_mdr;
      logic       sel_mdr;
      logic       halted;
      logic       illegal;
   } ctl_t;

   typedef struct {
      string tag;
      ctl_t  v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] IR = 16'h0000;
   logic        N = 1'b0, Z = 1'b0, P = 1'b0, mem_rdy = 1'b0;
   logic        mem_en, mem_we, enaALU, enaPC, enaMDR, enaMARM, logicWE, flagWE;
   logic        selMAR, selEAB1, ldPC, ldIR, ldMAR, ldMDR, selMDR, halted, illegal;
   logic [1:0]  aluControl, selPC, selEAB2;
   logic [2:0]  SR1, SR2, DR;
`ifdef LC3_CTRL_MEM_TIMEOUT_EN
   logic        timeout;
`endif

   int   n_run = 0;
   int   n_fail = 0;
   exp_t sb[$];
   ctl_t obs;

   always #5 clk = ~clk;

   lc3_control dut (
      .clk(clk), .rst_n(rst_n), .IR(IR), .N(N), .Z(Z), .P(P), .mem_rdy(mem_rdy),
      .mem_en(mem_en), .mem_we(mem_we), .aluControl(aluControl),
      .enaALU(enaALU), .enaPC(enaPC), .enaMDR(enaMDR), .enaMARM(enaMARM),
      .SR1(SR1), .SR2(SR2), .DR(DR), .logicWE(logicWE), .flagWE(flagWE),
      .selPC(selPC), .selMAR(selMAR), .selEAB1(selEAB1), .selEAB2(selEAB2),
      .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR),
      .halted(halted), .illegal(illegal)
`ifdef LC3_CTRL_MEM_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   assign obs = {mem_en, mem_we, aluControl, enaALU, enaPC, enaMDR, enaMARM, SR1, SR2, DR,
                 logicWE, flagWE, selPC, selMAR, selEAB1, selEAB2, ldPC, ldIR, ldMAR, ldMDR,
                 selMDR, halted, illegal};

   function automatic ctl_t e_f1();
      ctl_t e = '0;
      e.ena_pc = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1; e.sel_pc = 2'b00;
      return e;
   endfunction

   function automatic ctl_t e_rd(input logic rdy);
      ctl_t e = '0;
      e.mem_en = 1'b1; e.sel_mdr = 1'b1; e.ld_mdr = rdy;
      return e;
   endfunction

   function automatic ctl_t e_f3();
      ctl_t e = '0;
      e.ena_mdr = 1'b1; e.ld_ir = 1'b1;
      return e;
   endfunction

   function automatic ctl_t e_halt(input logic ill);
      ctl_t e = '0;
      e.halted = 1'b1; e.illegal = ill;
      return e;
   endfunction

   task automatic push(input string tag, input ctl_t v);
      exp_t x;
      x.tag = tag;
      x.v   = v;
      sb.push_back(x);
   endtask

   task automatic check_out();
      exp_t x;
      n_run++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %h required a queued expectation", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.v);
         end
      end
   endtask

   task automatic check_bit(input string tag, input logic o, input logic e);
      n_run++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, o, e);
      end
   endtask

   // one clock cycle: expectation queued with the stimulus, checked at the falling edge
   task automatic cyc(input string tag, input ctl_t v);
      push(tag, v);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string tag);
      cyc({tag, "_f1"}, e_f1());
      mem_rdy = 1'b1;
      cyc({tag, "_f2"}, e_rd(1'b1));
      cyc({tag, "_f3"}, e_f3());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ctl_t e;
      @(posedge clk);
      #1;
      cyc("reset", '0);
      rst_n = 1'b1;
      cyc("rst_release", '0);

      IR = 16'h1261;
      fetch("add");
      e = '0; e.ena_alu = 1'b1; e.alu = 2'b01; e.dr = 3'd1; e.sr1 = 3'd1; e.sr2 = 3'd1;
      e.logic_we = 1'b1; e.flag_we = 1'b1;
      cyc("add_dec", e);

      IR = 16'h0402; Z = 1'b1;
      fetch("brz_t");
      e = '0; e.ld_pc = 1'b1; e.sel_pc = 2'b01; e.sel_eab2 = 2'b10;
      cyc("brz_taken", e);
      Z = 1'b0; N = 1'b1; P = 1'b1;
      fetch("brz_n");
      cyc("brz_not_taken", '0);
      N = 1'b0; P = 1'b0;

      IR = 16'h3003;
      fetch("st");
      mem_rdy = 1'b0;
      cyc("st_dec", '0);
      e = '0; e.ena_marm = 1'b1; e.ld_mar = 1'b1; e.sel_eab2 = 2'b10;
      cyc("st_addr", e);
      e = '0; e.ena_alu = 1'b1; e.sr1 = 3'd0; e.ld_mdr = 1'b1;
      cyc("st_smdr", e);
      e = '0; e.mem_en = 1'b1; e.mem_we = 1'b1;
      for (int i = 0; i < 3; i++) cyc("st_wr_wait", e);
      mem_rdy = 1'b1;
      cyc("st_wr_done", e);

      IR = 16'h4040;
      fetch("jsrr");
      e = '0; e.ena_pc = 1'b1; e.logic_we = 1'b1; e.dr = 3'd7; e.ld_pc = 1'b1;
      e.sel_pc = 2'b01; e.sel_eab1 = 1'b1; e.sr1 = 3'd1; e.sel_eab2 = 2'b00;
      cyc("jsrr_dec", e);

      IR = 16'hC080;
      fetch("jmp");
      e = '0; e.ld_pc = 1'b1; e.sel_pc = 2'b01; e.sel_eab1 = 1'b1; e.sr1 = 3'd2;
      cyc("jmp_dec", e);

      IR = 16'hA405;
      fetch("ldi");
      cyc("ldi_dec", '0);
      e = '0; e.ena_marm = 1'b1; e.ld_mar = 1'b1; e.sel_eab2 = 2'b10;
      cyc("ldi_addr", e);
      cyc("ldi_rd1", e_rd(1'b1));
      e = '0; e.ena_mdr = 1'b1; e.ld_mar = 1'b1;
      cyc("ldi_ind", e);
      cyc("ldi_rd2", e_rd(1'b1));
      e = '0; e.ena_mdr = 1'b1; e.logic_we = 1'b1; e.flag_we = 1'b1; e.dr = 3'd2;
      cyc("ldi_wb", e);

      IR = 16'h6285;
      fetch("ldr");
      cyc("ldr_dec", '0);
      e = '0; e.ena_marm = 1'b1; e.ld_mar = 1'b1; e.sel_eab1 = 1'b1; e.sr1 = 3'd2; e.sel_eab2 = 2'b01;
      cyc("ldr_addr", e);
      cyc("ldr_rd", e_rd(1'b1));
      e = '0; e.ena_mdr = 1'b1; e.logic_we = 1'b1; e.flag_we = 1'b1; e.dr = 3'd1;
      cyc("ldr_wb", e);

      IR = 16'hF020;
      fetch("trap");
      cyc("trap_dec", '0);
      e = '0; e.ena_marm = 1'b1; e.sel_mar = 1'b1; e.ld_mar = 1'b1;
      cyc("trap_t1", e);
      e = '0; e.ena_pc = 1'b1; e.logic_we = 1'b1; e.dr = 3'd7;
      cyc("trap_t2", e);
      mem_rdy = 1'b0;
      cyc("trap_t3_wait", e_rd(1'b0));
      mem_rdy = 1'b1;
      cyc("trap_t3_done", e_rd(1'b1));
      e = '0; e.ena_mdr = 1'b1; e.ld_pc = 1'b1; e.sel_pc = 2'b10;
      cyc("trap_t4", e);

      IR = 16'hF025;
      fetch("halt");
      cyc("halt_dec", '0);
      e = '0; e.ena_marm = 1'b1; e.sel_mar = 1'b1; e.ld_mar = 1'b1;
      cyc("halt_t1", e);
      e = '0; e.ena_pc = 1'b1; e.logic_we = 1'b1; e.dr = 3'd7;
      cyc("halt_t2", e);
      cyc("halt_state", e_halt(1'b0));
      cyc("halt_absorb", e_halt(1'b0));

      rst_n = 1'b0;
      cyc("halt_reset", '0);
      rst_n = 1'b1;
      cyc("rst_release2", '0);
      IR = 16'h8000;
      fetch("rti");
      cyc("rti_dec", '0);
      cyc("rti_halt", e_halt(1'b1));
      cyc("rti_absorb", e_halt(1'b1));

      rst_n = 1'b0;
      cyc("reset3", '0);
      rst_n = 1'b1;
      cyc("rst_release3", '0);
      IR = 16'h1261;
      cyc("mid_f1", e_f1());
      mem_rdy = 1'b0;
      cyc("mid_f2_wait", e_rd(1'b0));
      rst_n = 1'b0;
      #1;
      push("mid_reset_drop", '0);
      check_out();
      @(posedge clk);
      #1;

`ifdef LC3_CTRL_MEM_TIMEOUT_EN
      rst_n = 1'b1;
      cyc("tmo_release", '0);
      cyc("tmo_f1", e_f1());
      check_bit("tmo_low", timeout, 1'b0);
      for (int i = 0; i < 255; i++) cyc("tmo_wait", e_rd(1'b0));
      cyc("tmo_halt", e_halt(1'b0));
      check_bit("tmo_high", timeout, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
